// File: rtl/add_pipe.sv
//------------------------------------------------------------------------------
// Module      : add_pipe
// Description : Carry-segmented pipelined adder/subtractor with valid/ready
//               flow control. Segment k of the carry chain resolves in stage k.
//               Optional saturation on signed overflow: define ADD_PIPE_SAT_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module add_pipe #(
   parameter int WIDTH = 32,
   parameter int SEGS  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int SW  = WIDTH / SEGS;
   localparam int NP  = (SEGS > 1) ? SEGS - 1 : 1;
   localparam int MSB = WIDTH - 1;

   generate
      if (SEGS < 1 || (WIDTH % SEGS) != 0) begin : g_bad_cfg
         $error("add_pipe: SEGS must be >= 1 and divide WIDTH");
      end
   endgenerate

   // Intermediate stages 0..SEGS-2; the last stage is the output register set
   logic [NP-1:0]    r_v;
   logic [NP-1:0]    r_c;
   logic [WIDTH-1:0] r_a [NP];
   logic [WIDTH-1:0] r_b [NP];
   logic [WIDTH-1:0] r_s [NP];

   logic             r_out_v;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;

   logic [WIDTH-1:0] w_a [SEGS];
   logic [WIDTH-1:0] w_b [SEGS];
   logic [WIDTH-1:0] w_s [SEGS];
   logic [SEGS-1:0]  w_c;
   logic             w_adv;
   logic             w_last_v;
   logic             w_ovf;
   logic [WIDTH-1:0] w_fsum;

   always_comb begin : p_stage
      logic [SW:0] v_seg;
      logic        v_cin;
      v_seg = '0;
      v_cin = 1'b0;
      for (int k = 0; k < SEGS; k++) begin
         w_a[k] = (k == 0) ? a : r_a[(k > 0) ? k - 1 : 0];
         w_b[k] = (k == 0) ? (sub ? ~b : b) : r_b[(k > 0) ? k - 1 : 0];
         w_s[k] = (k == 0) ? '0 : r_s[(k > 0) ? k - 1 : 0];
         v_cin  = (k == 0) ? sub : r_c[(k > 0) ? k - 1 : 0];
         v_seg  = {1'b0, w_a[k][k*SW +: SW]} + {1'b0, w_b[k][k*SW +: SW]}
                + {{SW{1'b0}}, v_cin};
         w_s[k][k*SW +: SW] = v_seg[SW-1:0];
         w_c[k] = v_seg[SW];
      end
   end

   always_comb begin : p_final
      w_adv    = !r_out_v || out_ready;
      w_last_v = (SEGS == 1) ? in_valid : r_v[NP-1];
      // w_b already holds the effective operand (~B for subtraction)
      w_ovf    = (w_a[SEGS-1][MSB] == w_b[SEGS-1][MSB]) &&
                 (w_s[SEGS-1][MSB] != w_a[SEGS-1][MSB]);
      w_fsum   = w_s[SEGS-1];
`ifdef ADD_PIPE_SAT_EN
      if (w_ovf) begin
         w_fsum = w_a[SEGS-1][MSB] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
      end
`else
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v     <= '0;
         r_c     <= '0;
         for (int k = 0; k < NP; k++) begin
            r_a[k] <= '0;
            r_b[k] <= '0;
            r_s[k] <= '0;
         end
         r_out_v <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_zero  <= 1'b0;
      end else if (w_adv) begin
         for (int k = 0; k < SEGS - 1; k++) begin
            r_v[k] <= (k == 0) ? in_valid : r_v[(k > 0) ? k - 1 : 0];
            r_a[k] <= w_a[k];
            r_b[k] <= w_b[k];
            r_s[k] <= w_s[k];
            r_c[k] <= w_c[k];
         end
         r_out_v <= w_last_v;
         r_sum   <= w_fsum;
         r_cout  <= w_c[SEGS-1];
         r_ovf   <= w_ovf;
         r_zero  <= (w_fsum == '0);
      end
   end

   assign in_ready  = w_adv;
   assign out_valid = r_out_v;
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;
   assign zero      = r_zero;

endmodule

`default_nettype wire

// File: tb/tb_add_pipe.sv
//------------------------------------------------------------------------------
// Module      : tb_add_pipe
// Description : Self-checking bench for add_pipe against a whole-word
//               arithmetic reference and a cycle-level delay-line model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_add_pipe;

   localparam int WIDTH = 32;
   localparam int SEGS  = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;
   logic             zero;

   int n_vec   = 0;
   int n_err   = 0;
   int or_mode = 0;
   bit post_rst = 1'b0;

   typedef struct {
      bit             v;
      logic [WIDTH-1:0] s;
      bit             c;
      bit             o;
      bit             z;
   } exp_t;

   exp_t pipe [SEGS];

   add_pipe #(.WIDTH(WIDTH), .SEGS(SEGS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [WIDTH-1:0] got,
                      input logic [WIDTH-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic exp_t ref_calc(input bit v, input logic [WIDTH-1:0] ta,
                                     input logic [WIDTH-1:0] tb, input bit ts);
      exp_t             e;
      logic [WIDTH-1:0] bb;
      logic [WIDTH:0]   full;
      bb   = ts ? ~tb : tb;
      full = {1'b0, ta} + {1'b0, bb} + {{WIDTH{1'b0}}, ts};
      e.v  = v;
      e.s  = full[WIDTH-1:0];
      e.c  = full[WIDTH];
      e.o  = (ta[WIDTH-1] == bb[WIDTH-1]) && (e.s[WIDTH-1] != ta[WIDTH-1]);
`ifdef ADD_PIPE_SAT_EN
      if (e.o) e.s = ta[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
      e.z  = (e.s == '0);
      return e;
   endfunction

   function automatic exp_t empty_slot();
      exp_t e;
      e.v = 1'b0; e.s = '0; e.c = 1'b0; e.o = 1'b0; e.z = 1'b0;
      return e;
   endfunction

   // Model: SEGS-deep delay line that shifts whenever the output slot is free or taken
   always @(negedge clk) begin
      exp_t last;
      last = pipe[SEGS-1];
      chk("out_valid", {31'b0, out_valid}, {31'b0, last.v});
      chk("in_ready", {31'b0, in_ready}, {31'b0, (!last.v || out_ready)});
      if (last.v) begin
         chk("sum",  sum, last.s);
         chk("cout", {31'b0, cout}, {31'b0, last.c});
         chk("ovf",  {31'b0, ovf},  {31'b0, last.o});
         chk("zero", {31'b0, zero}, {31'b0, last.z});
      end
      if (post_rst) begin
         chk("rst_sum",      sum, '0);
         chk("rst_flags",    {29'b0, cout, ovf, zero}, '0);
         chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      end
      post_rst = rst;
      if (rst) begin
         for (int k = 0; k < SEGS; k++) pipe[k] = empty_slot();
      end else if (!last.v || out_ready) begin
         for (int k = SEGS - 1; k > 0; k--) pipe[k] = pipe[k-1];
         pipe[0] = ref_calc(in_valid, a, b, sub);
      end
   end

   initial begin
      int p;
      p = 0;
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (or_mode)
            1:       out_ready = ((p % 4) == 0) || ((p % 4) == 3);
            2:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b1;
         endcase
         p++;
      end
   end

   task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                       input bit ts);
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      a        = ta;
      b        = tb;
      sub      = ts;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (in_ready) done = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!done) chk("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [WIDTH-1:0] pick();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h0000_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < SEGS; k++) pipe[k] = empty_slot();
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0;
      idle(3);
      rst = 1'b0;

      // Directed corner cases
      send(32'h0000_FFFF, 32'd1, 1'b0);
      idle(4);
      send(32'd5, 32'd5, 1'b1);
      send(32'h7FFF_FFFF, 32'd1, 1'b0);
      send(32'd0, 32'd1, 1'b1);
      idle(4);

      // Back-to-back beats under a 1,0,0,1 out_ready pattern
      or_mode = 1;
      for (int i = 0; i < 8; i++) send($urandom, $urandom, 1'($urandom_range(0, 1)));
      idle(12);
      or_mode = 0;
      idle(2);

      // Reset with two beats in flight, colliding with a new beat
      send(32'h1234_5678, 32'h1111_1111, 1'b0);
      send(32'hDEAD_BEEF, 32'h0000_0001, 1'b1);
      rst = 1'b1; in_valid = 1'b1; a = 32'hAAAA_AAAA; b = 32'h5555_5555; sub = 1'b0;
      idle(1);
      rst = 1'b0; in_valid = 1'b0;
      idle(5);

      // Random traffic with random back-pressure
      or_mode = 2;
      for (int i = 0; i < 3000; i++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         a        = pick();
         b        = pick();
         sub      = 1'($urandom_range(0, 1));
         idle(1);
      end
      in_valid = 1'b0;
      or_mode  = 0;
      idle(10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
